uart_char_source: RTL and testbench
===================================

UART_CHAR_SOURCE -- requirements
Module: uart_char_source

Interface
REQ-001 Parameter CLK_HZ, default 14318180, SHALL give the system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, SHALL give the serial bit rate; DIV = round(CLK_HZ/BAUD) clocks per bit (1491 at defaults).
REQ-003 Parameter FIFO_DEPTH, default 16, SHALL give the character FIFO depth; it is a power of two, minimum 2.
REQ-004 Parameter UPCASE, default 1, SHALL enable lowercase-to-uppercase folding when set to 1.
REQ-005 Port clk, input, 1, SHALL be the single system clock; all logic is rising-edge.
REQ-006 Port rst_n, input, 1, SHALL be the synchronous, active-low reset.
REQ-007 Port rx, input, 1, SHALL be the asynchronous 8N1 serial input, idle high.
REQ-008 Port rda_in, input, 1, SHALL be the terminal ready flag: 1 means ready, 0 means busy or accepted.
REQ-009 Port rd_out, output, 7 bits [7:1], SHALL be the character presented to the terminal rd_in.
REQ-010 Port da_out, output, 1, SHALL be the data-available strobe to the terminal da_in.
REQ-011 Port overrun, output, 1, SHALL be a sticky flag meaning a character was dropped because the FIFO was full.
REQ-012 Port frame_err, output, 1, SHALL be a one-clock pulse meaning a received stop bit was 0.

Function
REQ-013 rx SHALL pass through a 2-FF synchronizer before use; its latency is 2 clocks.
REQ-014 The receiver FSM SHALL have four states: IDLE, START, DATA, STOP.
- IDLE: goes to START on a synchronized falling edge, bit counter cleared.
REQ-015 In START, the receiver SHALL sample at DIV/2 clocks after the edge.
- If the sample is high: false start, return to IDLE with nothing stored.
- If the sample is low: go to DATA.
REQ-016 In DATA, the receiver SHALL sample 8 bits LSB-first, one every DIV clocks; the bit counter runs 0..7, then the FSM goes to STOP.
REQ-017 In STOP, the receiver SHALL sample once DIV clocks after the last data bit.
- Sample 1: the byte is valid.
- Sample 0: pulse frame_err for 1 clock, discard the byte.
- Either way, return to IDLE.
REQ-018 Each valid byte SHALL be processed in this order:
- drop bit 7;
- if UPCASE=1 and the value is 0x61..0x7A, subtract 0x20;
- write the 7-bit result to the FIFO in the clock after the STOP sample.
REQ-019 If the FIFO is full at write time, the byte SHALL be dropped, overrun set to 1, and FIFO contents left unchanged.
REQ-020 The FIFO SHALL use read and write pointers of log2(FIFO_DEPTH)+1 bits with natural wrap-around.
- empty: pointers equal.
- full: MSBs differ and the remaining bits are equal.
REQ-021 A simultaneous FIFO write and read SHALL both succeed, including when the FIFO is full or empty at that edge; count is unchanged.
REQ-022 The output FSM SHALL have three states: O_IDLE, O_PRESENT, O_RELEASE.
REQ-023 O_IDLE SHALL move to O_PRESENT when the FIFO is not empty and rda_in=1.
- At that edge: pop the FIFO head into rd_out and set da_out=1.
REQ-024 In O_PRESENT, rd_out SHALL stay stable and da_out=1 until rda_in=0 is sampled.
- Then da_out=0 and the FSM goes to O_RELEASE.
REQ-025 O_RELEASE SHALL return to O_IDLE when rda_in=1 is sampled; da_out stays 0 in O_RELEASE.
REQ-026 Handshake timing SHALL be as follows.
- Minimum spacing between da_out rising edges: 3 clocks.
- At most one character per terminal accept cycle.
- rd_out holds its last value outside O_PRESENT.
REQ-027 The receiver SHALL keep running while the output FSM waits; buffering is limited only by FIFO_DEPTH.

Reset
REQ-028 rst_n=0 at a rising edge of clk SHALL set the following:
- receiver FSM = IDLE, output FSM = O_IDLE;
- FIFO empty, counters 0;
- synchronizer flops = 1;
- rd_out=7'h00, da_out=0, overrun=0, frame_err=0.
REQ-029 A reset in the middle of a frame or handshake SHALL abandon it with no character output.
- After release, reception resumes at the next falling edge seen with rst_n=1.
REQ-030 The block SHALL not respond to rx, rda_in or any other input while rst_n=0.

Verification
REQ-031 Single character: rda_in=1, send 0x41 at BAUD.
- Expect da_out rise within 3 clocks after the STOP sample, rd_out=7'h41.
- Pull rda_in low: da_out falls next clock.
REQ-032 Case folding: send 0x61 with UPCASE=1 -> rd_out=7'h41. Send 0xC1 -> rd_out=7'h41. Send 0x7B -> rd_out=7'h7B.
REQ-033 Framing: send 0x41 with stop bit 0.
- Expect frame_err high for exactly 1 clock, FIFO empty, da_out stays 0.
- Then send a glitch on rx shorter than DIV/2 clocks: no start detected.
REQ-034 Overflow: hold rda_in=0, send FIFO_DEPTH+1 characters 0x30..0x40.
- Expect overrun=1 and 16 characters stored.
- Release rda_in: exactly 0x30..0x3F are output in order, one per handshake.
REQ-035 Handshake stall: keep rda_in=1 after da_out rises for 1000 clocks.
- Expect da_out held high and rd_out stable throughout.
- No second character is presented until rda_in goes 0 then 1.
REQ-036 Mid-operation reset: assert rst_n=0 halfway through the DATA bits while the FIFO holds 3 characters.
- Expect all outputs at their reset values next clock.
- No stale characters are output after release.
- A fresh 0x42 is then received correctly.

Source files
------------

// File: rtl/uart_char_source.sv
// uart_char_source: 8N1 serial receiver feeding a 7-bit character FIFO that is drained
// through a ready/data-available handshake. Ports: clk, rst_n (sync, active-low),
// rx (async serial in), rda_in (terminal ready), rd_out[7:1], da_out, overrun, frame_err.
module uart_char_source #(
    parameter int CLK_HZ     = 14318180,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16,
    parameter int UPCASE     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rda_in,
    output logic [7:1] rd_out,
    output logic       da_out,
    output logic       overrun,
    output logic       frame_err
);

    localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {O_IDLE, O_PRESENT, O_RELEASE} o_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            rx_s1_q,    rx_s1_d;
    logic            rx_s2_q,    rx_s2_d;
    logic            rx_prev_q,  rx_prev_d;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]      bit_cnt_q,  bit_cnt_d;
    logic [7:0]      shift_q,    shift_d;
    logic            wr_pend_q,  wr_pend_d;
    logic [6:0]      wr_dat_q,   wr_dat_d;
    logic            frame_err_q, frame_err_d;
    logic [AW:0]     wr_ptr_q,   wr_ptr_d;
    logic [AW:0]     rd_ptr_q,   rd_ptr_d;
    logic            overrun_q,  overrun_d;
    o_state_t        o_state_q,  o_state_d;
    logic [6:0]      rd_out_q,   rd_out_d;
    logic            da_out_q,   da_out_d;

    logic [6:0]      mem_q [FIFO_DEPTH];

    logic            rx_fall;
    logic [6:0]      folded;
    logic            fifo_empty;
    logic            fifo_full;
    logic [6:0]      fifo_head;
    logic            pop;
    logic            push;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    assign rx_fall = rx_prev_q & ~rx_s2_q;

    // Bit 7 dropped, optional lowercase fold on the remaining 7 bits.
    always_comb begin
        folded = shift_q[6:0];
        if (UPCASE == 1 && shift_q[6:0] >= 7'h61 && shift_q[6:0] <= 7'h7A) begin
            folded = shift_q[6:0] - 7'h20;
        end
    end

    always_comb begin
        rx_s1_d     = rx;
        rx_s2_d     = rx_s1_q;
        rx_prev_d   = rx_s2_q;
        rx_state_d  = rx_state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        wr_pend_d   = 1'b0;
        wr_dat_d    = wr_dat_q;
        frame_err_d = 1'b0;

        case (rx_state_q)
            IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                if (rx_fall) begin
                    rx_state_d = START;
                end
            end
            START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (baud_cnt_q == CW'(HALF - 1)) begin
                    baud_cnt_d = '0;
                    rx_state_d = rx_s2_q ? IDLE : DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (baud_cnt_q == CW'(DIV - 1)) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_s2_q, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_state_d = STOP;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (baud_cnt_q == CW'(DIV - 1)) begin
                    baud_cnt_d = '0;
                    rx_state_d = IDLE;
                    if (rx_s2_q) begin
                        wr_pend_d = 1'b1;
                        wr_dat_d  = folded;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // When empty, a byte being written this cycle is forwarded straight to
    // the output so a simultaneous write and read both succeed.
    assign fifo_head = fifo_empty ? wr_dat_q : mem_q[rd_ptr_q[AW-1:0]];

    assign pop  = (o_state_q == O_IDLE) && rda_in && (!fifo_empty || wr_pend_q);
    // A full FIFO still accepts a write if the head leaves on the same edge.
    assign push = wr_pend_q && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d  = wr_ptr_q + (AW + 1)'(push);
        rd_ptr_d  = rd_ptr_q + (AW + 1)'(pop);
        overrun_d = overrun_q | (wr_pend_q & fifo_full & ~pop);
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_q;
        end
    end

    // ------------------------------------------------------------------
    // Output handshake
    // ------------------------------------------------------------------
    always_comb begin
        o_state_d = o_state_q;
        rd_out_d  = rd_out_q;
        da_out_d  = da_out_q;

        case (o_state_q)
            O_IDLE: begin
                if (pop) begin
                    rd_out_d  = fifo_head;
                    da_out_d  = 1'b1;
                    o_state_d = O_PRESENT;
                end
            end
            O_PRESENT: begin
                if (!rda_in) begin
                    da_out_d  = 1'b0;
                    o_state_d = O_RELEASE;
                end
            end
            O_RELEASE: begin
                // Wait for the terminal to become ready again before the
                // next character, so one character per accept cycle.
                da_out_d = 1'b0;
                if (rda_in) begin
                    o_state_d = O_IDLE;
                end
            end
            default: begin
                da_out_d  = 1'b0;
                o_state_d = O_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            wr_pend_q   <= 1'b0;
            wr_dat_q    <= '0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overrun_q   <= 1'b0;
            o_state_q   <= O_IDLE;
            rd_out_q    <= '0;
            da_out_q    <= 1'b0;
        end else begin
            rx_s1_q     <= rx_s1_d;
            rx_s2_q     <= rx_s2_d;
            rx_prev_q   <= rx_prev_d;
            rx_state_q  <= rx_state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            wr_pend_q   <= wr_pend_d;
            wr_dat_q    <= wr_dat_d;
            frame_err_q <= frame_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overrun_q   <= overrun_d;
            o_state_q   <= o_state_d;
            rd_out_q    <= rd_out_d;
            da_out_q    <= da_out_d;
        end
    end

    assign rd_out    = rd_out_q;
    assign da_out    = da_out_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_char_source.sv
// Bench for uart_char_source: serial stimulus, terminal handshake emulation, scoreboard.
// Runs at DIV=16 clocks per bit to keep the run short.
// Expected characters are queued when sent and compared when da_out rises.
module tb_uart_char_source;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int DIV    = 16;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       rx     = 1'b1;
    logic       rda_in = 1'b0;
    logic [7:1] rd_out;
    logic       da_out;
    logic       overrun;
    logic       frame_err;

    uart_char_source #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(16),
        .UPCASE    (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rda_in   (rda_in),
        .rd_out   (rd_out),
        .da_out   (da_out),
        .overrun  (overrun),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [6:0] fold(input logic [7:0] b);
        logic [6:0] v;
        v = b[6:0];
        if (v >= 7'h61 && v <= 7'h7A) v = v - 7'h20;
        return v;
    endfunction

    // Scoreboard and output monitor
    logic [6:0] exp_q[$];
    logic       da_prev    = 1'b0;
    int         rises      = 0;
    int         fe_cycles  = 0;

    always @(negedge clk) begin
        if (frame_err) fe_cycles++;
        if (da_out && !da_prev) begin
            rises++;
            check_eq("present_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check_eq("rd_out", int'(rd_out), int'(exp_q.pop_front()));
        end
        da_prev = da_out;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Terminal side: become ready, wait for a character, accept it.
    task automatic handshake();
        int t;
        t = 0;
        rda_in = 1'b1;
        while (!da_out && t < 20 * DIV) begin
            @(negedge clk);
            t++;
        end
        check_eq("da_wait", int'(da_out), 1);
        if (da_out) begin
            @(negedge clk);
            rda_in = 1'b0;
            @(negedge clk);
            check_eq("da_fall", int'(da_out), 0);
        end
    endtask

    int         r0;
    int         fe0;
    int         bad;
    logic [6:0] saved;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_da_out", int'(da_out), 0);
        check_eq("rst_rd_out", int'(rd_out), 0);
        check_eq("rst_overrun", int'(overrun), 0);
        check_eq("rst_frame_err", int'(frame_err), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single character with terminal ready
        rda_in = 1'b1;
        exp_q.push_back(fold(8'h41));
        send_byte(8'h41, 1'b1);
        check_eq("single_da_up", int'(da_out), 1);
        handshake();

        // Case folding
        exp_q.push_back(fold(8'h61));
        send_byte(8'h61, 1'b1);
        handshake();
        exp_q.push_back(fold(8'hC1));
        send_byte(8'hC1, 1'b1);
        handshake();

        // Framing error, then a short glitch
        rda_in = 1'b1;
        r0  = rises;
        fe0 = fe_cycles;
        send_byte(8'h41, 1'b0);
        repeat (DIV) @(negedge clk);
        check_eq("fe_pulse_len", fe_cycles - fe0, 1);
        check_eq("fe_no_char", rises - r0, 0);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        check_eq("glitch_no_char", rises - r0, 0);
        check_eq("glitch_no_fe", fe_cycles - fe0, 1);

        // Receiver recovered; boundary just above 'z'
        exp_q.push_back(fold(8'h7B));
        send_byte(8'h7B, 1'b1);
        handshake();

        // Handshake stall with a second character arriving meanwhile
        rda_in = 1'b1;
        exp_q.push_back(fold(8'h55));
        send_byte(8'h55, 1'b1);
        check_eq("stall_da_up", int'(da_out), 1);
        saved = rd_out;
        r0    = rises;
        bad   = 0;
        fork
            begin
                exp_q.push_back(fold(8'h56));
                send_byte(8'h56, 1'b1);
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    @(negedge clk);
                    if (da_out !== 1'b1 || rd_out !== saved) bad++;
                end
            end
        join
        check_eq("stall_stable", bad, 0);
        check_eq("stall_no_second", rises - r0, 0);
        handshake();
        handshake();

        // Overflow: 17 characters into a 16-deep FIFO, terminal not ready
        rda_in = 1'b0;
        r0 = rises;
        for (int c = 8'h30; c <= 8'h3F; c++) begin
            exp_q.push_back(fold(8'(c)));
            send_byte(8'(c), 1'b1);
        end
        check_eq("ovf_not_yet", int'(overrun), 0);
        send_byte(8'h40, 1'b1);
        check_eq("ovf_set", int'(overrun), 1);
        check_eq("ovf_no_output", rises - r0, 0);
        for (int k = 0; k < 16; k++) handshake();
        rda_in = 1'b1;
        repeat (4 * DIV) @(negedge clk);
        check_eq("ovf_drain_count", rises - r0, 16);
        check_eq("ovf_sb_empty", exp_q.size(), 0);

        // Mid-frame reset with 3 characters buffered
        rda_in = 1'b0;
        send_byte(8'h31, 1'b1);
        send_byte(8'h32, 1'b1);
        send_byte(8'h33, 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(8'h44 >> i);
            repeat (DIV) @(negedge clk);
        end
        rst_n  = 1'b0;
        rda_in = 1'b1;
        @(negedge clk);
        check_eq("mrst_da_out", int'(da_out), 0);
        check_eq("mrst_rd_out", int'(rd_out), 0);
        check_eq("mrst_overrun", int'(overrun), 0);
        check_eq("mrst_frame_err", int'(frame_err), 0);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("mrst_ignores_inputs", int'(da_out), 0);
        r0 = rises;
        rst_n = 1'b1;
        repeat (4 * DIV) @(negedge clk);
        check_eq("mrst_no_stale", rises - r0, 0);
        exp_q.push_back(fold(8'h42));
        send_byte(8'h42, 1'b1);
        handshake();
        rda_in = 1'b1;
        repeat (4 * DIV) @(negedge clk);
        check_eq("mrst_one_char", rises - r0, 1);
        check_eq("final_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
